// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache with single-word fills.
// Hits are combinational; a miss runs one IDLE->FILL->IDLE fill over the
// iREN/iwait handshake.
// Optional macro ICACHE_PERF_CNT_EN adds saturating hit_cnt/miss_cnt outputs.
module icache_dm #(
   parameter int unsigned SETS = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
`ifdef ICACHE_PERF_CNT_EN
  ,output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned TAG_W = 30 - IDX_W;

   typedef enum logic {IDLE, FILL} state_t;

   state_t           state, next_state;
   logic [SETS-1:0]  valid;
   logic [TAG_W-1:0] tag_arr  [SETS];
   logic [31:0]      data_arr [SETS];
   logic [29:0]      fill_word;
   logic [IDX_W-1:0] req_idx, fill_idx;
   logic [TAG_W-1:0] req_tag, fill_tag;
   logic             hit, miss, fill_done;
   logic             unused_addr_lsbs;

   // Address split for the live request and the latched miss address.
   always_comb begin
      req_idx          = imemaddr[IDX_W+1:2];
      req_tag          = imemaddr[31:IDX_W+2];
      fill_idx         = fill_word[IDX_W-1:0];
      fill_tag         = fill_word[29:IDX_W];
      unused_addr_lsbs = &imemaddr[1:0];
   end

   // Hit detection and read-data return; hits are only honoured in IDLE.
   always_comb begin
      hit      = imemREN && valid[req_idx] && (tag_arr[req_idx] == req_tag) && (state == IDLE);
      miss     = imemREN && !hit && (state == IDLE);
      ihit     = hit;
      imemload = hit ? data_arr[req_idx] : '0;
   end

   // Next-state and memory-port outputs.
   always_comb begin
      next_state = state;
      iREN       = 1'b0;
      iaddr      = '0;
      fill_done  = 1'b0;
      unique case (state)
         IDLE: begin
            if (miss) next_state = FILL;
         end
         FILL: begin
            iREN  = 1'b1;
            iaddr = {fill_word, 2'b00};
            if (!iwait) begin
               fill_done  = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State, valid bits and the latched miss address; reset cancels any fill.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         valid     <= '0;
         fill_word <= '0;
      end else begin
         state <= next_state;
         if (miss) fill_word <= imemaddr[31:2];
         if (fill_done) valid[fill_idx] <= 1'b1;
      end
   end

   // Tag and data storage; contents are meaningless until the valid bit is set.
   always_ff @(posedge CLK) begin
      if (fill_done) begin
         tag_arr[fill_idx]  <= fill_tag;
         data_arr[fill_idx] <= iload;
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   // Saturating performance counters for hits and fill starts.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (hit && (hit_cnt != '1)) hit_cnt <= hit_cnt + 32'd1;
         if (miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed plus random fetch sequences against a line-map
// reference model of a direct-mapped word cache.
module tb_icache_dm;

   localparam int unsigned SETS = 16;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        imemREN = 1'b0;
   logic [31:0] imemaddr = '0;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait = 1'b1;
   logic [31:0] iload = '0;
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   icache_dm #(.SETS(SETS)) dut (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
      .iwait(iwait), .iload(iload)
`ifdef ICACHE_PERF_CNT_EN
     ,.hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned exp_hits = 0, exp_misses = 0;

   // memory contents keyed by word address; cache model: line index -> word address held
   logic [31:0] mem   [int unsigned];
   int unsigned model [int unsigned];

   function automatic logic [31:0] mem_word(input int unsigned w);
      if (!mem.exists(w)) mem[w] = $urandom;
      return mem[w];
   endfunction

   function automatic bit model_hit(input logic [31:0] a);
      int unsigned w = a >> 2;
      int unsigned i = w % SETS;
      return model.exists(i) && (model[i] == w);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One request issued just after a rising edge with the DUT in IDLE.
   // On a miss, runs the fill with nwait busy cycles; optionally changes the
   // request during the fill. Returns just after the edge ending the fill.
   task automatic fetch(input logic [31:0] a, input int unsigned nwait,
                        input bit do_sw, input logic [31:0] sw_a, input bit sw_ren);
      bit          h;
      logic [31:0] d;
      h = model_hit(a);
      d = mem_word(a >> 2);
      imemREN  = 1'b1;
      imemaddr = a;
      iwait    = 1'b1;
      @(negedge CLK);
      check("req_ihit", {31'd0, ihit}, {31'd0, h});
      check("req_data", imemload, h ? d : 32'h0);
      check("req_iren", {31'd0, iREN}, 32'd0);
      @(posedge CLK); #1;
      if (h) begin
         exp_hits++;
         return;
      end
      exp_misses++;
      for (int unsigned k = 0; k <= nwait; k++) begin
         if (do_sw && k == 0) begin
            imemaddr = sw_a;
            imemREN  = sw_ren;
         end
         iwait = (k < nwait);
         iload = (k < nwait) ? $urandom : d;
         @(negedge CLK);
         check("fill_iren",  {31'd0, iREN}, 32'd1);
         check("fill_iaddr", iaddr, a & 32'hFFFF_FFFC);
         check("fill_ihit",  {31'd0, ihit}, 32'd0);
         @(posedge CLK); #1;
      end
      model[(a >> 2) % SETS] = a >> 2;
      iwait = 1'b1;
   endtask

   task automatic idle_cycle();
      imemREN  = 1'b0;
      imemaddr = $urandom;
      @(negedge CLK);
      check("idle_ihit", {31'd0, ihit}, 32'd0);
      check("idle_data", imemload, 32'h0);
      check("idle_iren", {31'd0, iREN}, 32'd0);
      @(posedge CLK); #1;
   endtask

   initial begin
      logic [31:0] ra;
      mem[32'h40 >> 2] = 32'h8C22_0004;

      // reset state
      #12;
      imemREN = 1'b1; imemaddr = 32'h40;
      #1;
      check("rst_ihit",  {31'd0, ihit}, 32'd0);
      check("rst_iren",  {31'd0, iREN}, 32'd0);
      check("rst_iaddr", iaddr, 32'h0);
      @(posedge CLK); #1;
      nRST = 1'b1;

      // cold miss with two busy cycles, then hits (incl. unaligned byte address)
      fetch(32'h40, 2, 0, 0, 0);
      fetch(32'h40, 0, 0, 0, 0);
      fetch(32'h42, 0, 0, 0, 0);
      idle_cycle();

      // conflict eviction at index 0
      fetch(32'h80, 1, 0, 0, 0);
      fetch(32'h80, 0, 0, 0, 0);
      fetch(32'h40, 1, 0, 0, 0);
      fetch(32'h40, 0, 0, 0, 0);

      // address change and request drop during fill
      fetch(32'h100, 2, 1, 32'h104, 1);
      fetch(32'h104, 1, 0, 0, 0);
      fetch(32'h100, 0, 0, 0, 0);
      fetch(32'h200, 1, 1, 32'h40, 0);
      fetch(32'h200, 0, 0, 0, 0);

`ifdef ICACHE_PERF_CNT_EN
      check("hit_cnt",  hit_cnt,  exp_hits);
      check("miss_cnt", miss_cnt, exp_misses);
`endif

      // reset mid-fill
      imemREN = 1'b1; imemaddr = 32'h300; iwait = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK);
      check("pre_rst_iren", {31'd0, iREN}, 32'd1);
      #2 nRST = 1'b0;
      #1;
      check("mid_rst_iren", {31'd0, iREN}, 32'd0);
      check("mid_rst_ihit", {31'd0, ihit}, 32'd0);
      model.delete();
      exp_hits = 0; exp_misses = 0;
      @(posedge CLK); #1;
      nRST = 1'b1;
      fetch(32'h40, 0, 0, 0, 0);
      fetch(32'h40, 0, 0, 0, 0);
      fetch(32'h40, 0, 0, 0, 0);
      fetch(32'h40, 0, 0, 0, 0);
`ifdef ICACHE_PERF_CNT_EN
      check("hit_cnt_seq",  hit_cnt,  32'd3);
      check("miss_cnt_seq", miss_cnt, 32'd1);
`endif

      // random traffic over a small footprint to mix hits and conflicts
      for (int unsigned n = 0; n < 60; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            idle_cycle();
         end else begin
            ra = ($urandom_range(0, 3 * SETS - 1) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) ra[27] = 1'b1;
            if ($urandom_range(0, 4) == 0)
               fetch(ra, $urandom_range(0, 3), 1, $urandom_range(0, 255) << 2, $urandom_range(0, 1));
            else
               fetch(ra, $urandom_range(0, 3), 0, 0, 0);
         end
      end
`ifdef ICACHE_PERF_CNT_EN
      check("hit_cnt_rand",  hit_cnt,  exp_hits);
      check("miss_cnt_rand", miss_cnt, exp_misses);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the pipeline fetch stage and the memory controller instruction port.
- Serves `imemREN` / `imemaddr` requests from the fetch stage.
  - Returns `ihit` and `imemload` combinationally on a hit.
  - On a miss, runs a single-word fill from memory using an `iREN` / `iwait` handshake.
- The fetch stage advances the PC only when `ihit`=1.

Parameters:
- SETS, 16, number of cache lines; power of two, 2..256.
- IDX_W, $clog2(SETS), index width (derived; do not override).
- TAG_W, 30-IDX_W, tag width (derived).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset; asynchronous, active-low.
- imemREN  in  1  fetch request from datapath.
- imemaddr  in  32  fetch byte address.
- ihit  out  1  requested word valid this cycle.
- imemload  out  32  instruction word.
- iREN  out  1  read request to memory controller.
- iaddr  out  32  memory read address.
- iwait  in  1  1 = memory busy; 0 = iload valid this cycle.
- iload  in  32  memory read data.

Behaviour:

Address split:
- addr[1:0] is ignored; all accesses are word-aligned.
- idx = addr[IDX_W+1:2].
- tag = addr[31:IDX_W+2].

Storage:
- Per line: valid bit, tag of TAG_W bits, data of 32 bits.
- Reset clears all valid bits. Tag and data are don't-care after reset.

Hit logic (combinational):
- hit = imemREN & valid[idx] & (tagarr[idx]==tag) & (state==IDLE).
- ihit = hit.
- imemload = data[idx] when hit, else 32'h0.

FSM states: IDLE, FILL.
- IDLE:
  - If imemREN & !hit: latch the miss address into fill_addr and go to FILL.
  - Otherwise stay in IDLE.
- FILL:
  - iREN=1, iaddr={fill_addr[31:2],2'b00}.
  - When iwait=0: write line[fill idx] with valid=1, tag=fill tag, data=iload; go to IDLE.
  - When iwait=1: stay in FILL and hold iREN and iaddr stable.
- Outputs in IDLE: iREN=0, iaddr=32'h0.

Latency:
- Hit: 0 cycles (same cycle as request).
- Miss: 1 cycle (IDLE→FILL) + N memory wait cycles, then 1 cycle back in IDLE, where the request hits.
- ihit is never asserted in FILL, including the completion cycle.

Boundary conditions:
- imemREN drops or imemaddr changes during FILL: the fill completes with the latched address. The new address is evaluated in IDLE afterwards. Fills are never aborted.
- Fill to a line whose index matches a valid line with a different tag: the old line is overwritten (replacement).
- imemREN=0 in IDLE: no state change, ihit=0.
- Reset asserted mid-FILL: iREN goes to 0 immediately (async), state=IDLE, all valid bits cleared. No line write occurs.
- There is no coherence with data-side writes; self-modifying code is unsupported.

Optional Feature:

Macro ICACHE_PERF_CNT_EN.
- Defined:
  - Adds outputs hit_cnt (out, 32) and miss_cnt (out, 32), both reset to 0.
  - hit_cnt increments on each cycle with ihit=1.
  - miss_cnt increments on each IDLE→FILL transition.
  - Both counters saturate at 32'hFFFFFFFF; they do not wrap.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: after reset, imemREN=1, imemaddr=0x00000040. Memory holds iwait=1 for 2 cycles, then iwait=0 with iload=0x8C220004.
  - Required: iREN=1 with iaddr=0x40 for 3 cycles; ihit=1, imemload=0x8C220004 on the following cycle.
- Hit after fill:
  - Stimulus: re-request 0x00000040 and also 0x00000042.
  - Required: ihit=1 in the same cycle, imemload=0x8C220004, iREN=0.
- Conflict eviction (SETS=16):
  - Stimulus: fill 0x00000040, then request 0x00000080 (same idx 0, different tag).
  - Required: miss and fill. A subsequent request to 0x40 misses again.
- Address change mid-fill:
  - Stimulus: miss on 0x100; during FILL switch imemaddr to 0x104.
  - Required: iaddr stays 0x100 until iwait=0; then 0x104 misses and a new fill starts with iaddr=0x104.
- Reset mid-fill:
  - Stimulus: assert nRST=0 during FILL with iwait=1.
  - Required: iREN=0 immediately. After release, the earlier-filled address 0x40 misses.
- With ICACHE_PERF_CNT_EN:
  - Stimulus: the sequence miss 0x40, hit 0x40 ×3.
  - Required: miss_cnt=1, hit_cnt=3.
